ddr_lane_arbiter: RTL and testbench
===================================

Name: ddr_lane_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one dual-edge (DDR) output lane among NUM_REQ requesters.
- Each accepted beat carries two words: word 0 for the clock-high phase, word 1 for the clock-low phase.
- Registered words drive the downstream dual-edge capture/mux stage, which outputs lane_hi_data while clk=1 and lane_lo_data while clk=0.
- Bursts are bounded by req_last or MAX_BURST so no requester can starve the others.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, width of one lane word
MAX_BURST, 4, maximum beats per grant (>=1)

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
lane_en  input  1  downstream lane enable; 0 stalls all transfers
req_valid  input  NUM_REQ  per-requester beat valid
req_data  input  NUM_REQ*2*DATA_W  requester i occupies slice [i*2*DATA_W +: 2*DATA_W]; low DATA_W bits = word 0 (hi phase), high DATA_W bits = word 1 (lo phase)
req_last  input  NUM_REQ  final beat of requester's burst
req_ready  output  NUM_REQ  per-requester beat accept (combinational)
lane_hi_data  output  DATA_W  registered word 0 of last accepted beat
lane_lo_data  output  DATA_W  registered word 1 of last accepted beat
lane_vld  output  1  registered: lane words are valid this cycle
lane_owner  output  clog2(NUM_REQ)  index of the current/last granted requester
busy  output  1  1 while state is BURST

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, lane_owner=0, beat_cnt=0, lane_vld=0, lane_hi_data=0, lane_lo_data=0. req_ready=0 while in IDLE. Reset mid-burst drops any beat not yet registered; no partial output.
- States: IDLE, BURST.
- IDLE: if lane_en=1 and any req_valid=1, select the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ. Latch lane_owner=i, beat_cnt=0, go to BURST. No beat is accepted in this cycle: there is one bubble cycle per grant.
- BURST: req_ready[lane_owner]=lane_en; all other req_ready bits are 0. Handshake = req_valid & req_ready.
- On handshake: at the next posedge, lane_hi_data and lane_lo_data take the owner's words and lane_vld=1. Latency from accept edge to lane_vld is 1 cycle.
- No handshake in a cycle: lane_vld=0 next cycle; lane data holds its previous value.
- Burst end: a handshake with req_last[owner]=1, or with beat_cnt==MAX_BURST-1, sends the FSM to IDLE with rr_ptr=(owner+1) mod NUM_REQ. Otherwise beat_cnt increments on each handshake.
- Owner drops req_valid mid-burst: the grant is kept, lane_vld=0 for those cycles, and there is no timeout.
- lane_en=0: no handshakes, state and beat_cnt hold, lane_vld=0 next cycle. In IDLE, no grant is made.
- req_last and the MAX_BURST limit on the same beat produce a single end (no double rotation).
- Requesters that are not granted see req_ready=0 regardless of req_valid. Their req_data is ignored.
- busy = (state==BURST).
- rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Reset then req_valid=4'b0001, one beat with data hi=8'hA5, lo=8'h5A, last=1. Required: grant (busy=1) at the 1st edge; handshake in the following cycle; lane_vld=1 with hi=A5, lo=5A one cycle later; FSM returns to IDLE; rr_ptr=1.
- All four requesters valid continuously, each giving 2-beat bursts. Required: owners in order 0,1,2,3,0; one bubble cycle between grants; req_ready is one-hot or zero every cycle.
- Requester 2 alone, never asserting last, MAX_BURST=4. Required: exactly 4 lane_vld pulses, then IDLE; a regrant to requester 2 after the bubble (only requester valid).
- Mid-burst, owner deasserts valid for 3 cycles, then lane_en=0 for 2 cycles. Required: lane_vld=0 in each stalled cycle, lane_owner unchanged, beat_cnt unchanged, and the burst completes afterwards.
- rst_n=0 asserted during the 2nd beat of a burst. Required: next edge gives lane_vld=0, data=0, busy=0, lane_owner=0; the first grant after release goes to the lowest-indexed valid requester.

Source files
------------

// File: rtl/ddr_lane_arbiter.sv
// Round-robin scheduler sharing one dual-edge output lane among NUM_REQ requesters.
// Each accepted beat is registered as a hi-phase / lo-phase word pair for the DDR capture stage.
module ddr_lane_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          lane_en,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*2*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_W-1:0]             lane_hi_data,
   output logic [DATA_W-1:0]             lane_lo_data,
   output logic                          lane_vld,
   output logic [$clog2(NUM_REQ)-1:0]    lane_owner,
   output logic                          busy
);

   localparam int unsigned OW = $clog2(NUM_REQ);
   localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   logic [0:0]          state;
   logic [OW-1:0]       rr_ptr;
   logic [BW-1:0]       beat_cnt;

   logic                found;
   logic [OW-1:0]       pick;
   int unsigned         idx;

   logic [2*DATA_W-1:0] own_words;
   logic                own_valid;
   logic                own_last;
   logic                hs;
   logic                burst_end;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = OW'(idx);
         end
      end
   end

   always_comb begin
      own_words = '0;
      own_valid = 1'b0;
      own_last  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (lane_owner == OW'(i)) begin
            own_words = req_data[i*2*DATA_W +: 2*DATA_W];
            own_valid = req_valid[i];
            own_last  = req_last[i];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == BURST) begin
         req_ready[lane_owner] = lane_en;
      end
   end

   assign hs        = (state == BURST) && lane_en && own_valid;
   assign burst_end = own_last || (beat_cnt == BW'(MAX_BURST - 1));
   assign busy      = (state == BURST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         lane_owner   <= '0;
         beat_cnt     <= '0;
         lane_vld     <= 1'b0;
         lane_hi_data <= '0;
         lane_lo_data <= '0;
      end else begin
         lane_vld <= hs;
         if (hs) begin
            lane_hi_data <= own_words[DATA_W-1:0];
            lane_lo_data <= own_words[2*DATA_W-1:DATA_W];
         end
         case (state)
            IDLE: begin
               if (lane_en && found) begin
                  lane_owner <= pick;
                  beat_cnt   <= '0;
                  state      <= BURST;
               end
            end
            default: begin
               if (hs) begin
                  if (burst_end) begin
                     state  <= IDLE;
                     rr_ptr <= (lane_owner == OW'(NUM_REQ - 1)) ? '0 : lane_owner + 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_lane_arbiter.sv
// Bench for ddr_lane_arbiter: directed scenarios plus random traffic checked against
// a transaction-level model of grants, bursts and the registered lane words.
module tb_ddr_lane_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic              clk;
   logic              rst_n;
   logic              lane_en;
   logic [N-1:0]      req_valid;
   logic [N*2*DW-1:0] req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic [DW-1:0]     lane_hi_data;
   logic [DW-1:0]     lane_lo_data;
   logic              lane_vld;
   logic [1:0]        lane_owner;
   logic              busy;

   int checks = 0;
   int errors = 0;

   // reference model
   bit          m_known = 0;
   bit          m_granted;
   int          m_owner;
   int          m_beats;
   int          m_ptr;
   bit          m_vld;
   logic [7:0]  m_hi;
   logic [7:0]  m_lo;

   ddr_lane_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .lane_en(lane_en), .req_valid(req_valid),
      .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .lane_hi_data(lane_hi_data), .lane_lo_data(lane_lo_data), .lane_vld(lane_vld),
      .lane_owner(lane_owner), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic model_edge();
      bit accepted;
      if (!rst_n) begin
         m_known = 1; m_granted = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
         m_vld = 0; m_hi = 0; m_lo = 0;
         return;
      end
      accepted = m_granted && lane_en && req_valid[m_owner];
      m_vld = accepted;
      if (accepted) begin
         m_hi = req_data[m_owner*16 +: 8];
         m_lo = req_data[m_owner*16 + 8 +: 8];
         m_beats++;
         if (req_last[m_owner] || m_beats == MB) begin
            m_granted = 0;
            m_ptr = (m_owner + 1) % N;
         end
      end else if (!m_granted && lane_en && req_valid != 0) begin
         for (int k = 0; k < N; k++) begin
            if (!m_granted && req_valid[(m_ptr + k) % N]) begin
               m_granted = 1;
               m_owner = (m_ptr + k) % N;
               m_beats = 0;
            end
         end
      end
   endtask

   // One clock: check combinational ready, advance, check registered outputs.
   task automatic cycle();
      logic [N-1:0] exp_rdy;
      #1;
      exp_rdy = '0;
      if (m_granted && lane_en) exp_rdy[m_owner] = 1'b1;
      if (m_known) begin
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL req_ready t=%0t got %b want %b", $time, req_ready, exp_rdy);
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      checks++;
      if (lane_vld !== m_vld || busy !== m_granted || lane_owner !== 2'(m_owner) ||
          lane_hi_data !== m_hi || lane_lo_data !== m_lo) begin
         errors++;
         $display("FAIL outputs t=%0t got vld=%b busy=%b own=%0d hi=%h lo=%h want vld=%b busy=%b own=%0d hi=%h lo=%h",
                  $time, lane_vld, busy, lane_owner, lane_hi_data, lane_lo_data,
                  m_vld, m_granted, m_owner, m_hi, m_lo);
      end
   endtask

   task automatic do_reset();
      rst_n = 0; lane_en = 1; req_valid = '0; req_last = '0;
      cycle();
      rst_n = 1;
   endtask

   task automatic test_reset();
      req_data = '1;
      do_reset();
      cycle();
      checks++;
      if (lane_vld !== 0 || busy !== 0 || lane_owner !== 0 || lane_hi_data !== 0 || lane_lo_data !== 0) begin
         errors++;
         $display("FAIL reset_state got vld=%b busy=%b own=%0d hi=%h lo=%h want all zero",
                  lane_vld, busy, lane_owner, lane_hi_data, lane_lo_data);
      end
   endtask

   task automatic test_single_beat();
      do_reset();
      req_data = '0;
      req_data[15:0] = 16'h5AA5;
      req_valid = 4'b0001; req_last = 4'b0001;
      cycle();
      checks++;
      if (busy !== 1 || lane_owner !== 0 || lane_vld !== 0) begin
         errors++;
         $display("FAIL single_grant got busy=%b own=%0d vld=%b want 1 0 0", busy, lane_owner, lane_vld);
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready got %b want 0001", req_ready);
      end
      cycle();
      checks++;
      if (lane_vld !== 1 || lane_hi_data !== 8'hA5 || lane_lo_data !== 8'h5A || busy !== 0) begin
         errors++;
         $display("FAIL single_beat got vld=%b hi=%h lo=%h busy=%b want 1 a5 5a 0",
                  lane_vld, lane_hi_data, lane_lo_data, busy);
      end
      req_valid = 4'b1111; req_last = 4'b1111;
      cycle();
      checks++;
      if (lane_owner !== 1 || lane_vld !== 0) begin
         errors++;
         $display("FAIL single_rrptr got own=%0d vld=%b want 1 0", lane_owner, lane_vld);
      end
      cycle();
      req_valid = '0;
      cycle();
   endtask

   task automatic test_round_robin();
      int owners[$];
      int want[5] = '{0, 1, 2, 3, 0};
      bit prev_busy;
      do_reset();
      req_valid = 4'b1111;
      prev_busy = 0;
      for (int c = 0; c < 15; c++) begin
         req_data = {$urandom(), $urandom()};
         req_last = (m_granted && m_beats == 1) ? 4'b1111 : 4'b0000;
         #1;
         checks++;
         if (!$onehot0(req_ready)) begin
            errors++;
            $display("FAIL rr_onehot got %b want one-hot or zero", req_ready);
         end
         cycle();
         if (busy && !prev_busy) owners.push_back(int'(lane_owner));
         prev_busy = busy;
      end
      checks++;
      if (owners.size() != 5) begin
         errors++;
         $display("FAIL rr_count got %0d grants want 5", owners.size());
      end
      for (int i = 0; i < 5 && i < owners.size(); i++) begin
         checks++;
         if (owners[i] != want[i]) begin
            errors++;
            $display("FAIL rr_order[%0d] got %0d want %0d", i, owners[i], want[i]);
         end
      end
      req_valid = '0; req_last = '0;
      cycle();
   endtask

   task automatic test_max_burst();
      int pulses = 0;
      int budget = 0;
      do_reset();
      req_valid = 4'b0100; req_last = '0;
      req_data = {$urandom(), $urandom()};
      cycle();
      do begin
         req_data = {$urandom(), $urandom()};
         cycle();
         if (lane_vld) pulses++;
         budget++;
      end while (busy && budget < 12);
      checks++;
      if (pulses != MB || busy !== 0) begin
         errors++;
         $display("FAIL max_burst got %0d pulses busy=%b want %0d pulses busy=0", pulses, busy, MB);
      end
      cycle();
      checks++;
      if (busy !== 1 || lane_owner !== 2) begin
         errors++;
         $display("FAIL max_regrant got busy=%b own=%0d want 1 2", busy, lane_owner);
      end
      req_valid = '0;
      do_reset();
   endtask

   task automatic test_stall();
      int pulses = 0;
      do_reset();
      req_valid = 4'b0010; req_last = '0;
      req_data = {$urandom(), $urandom()};
      cycle();
      cycle();
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin req_valid = '0; lane_en = 1; end
         else begin req_valid = 4'b0010; lane_en = 0; end
         req_data = {$urandom(), $urandom()};
         cycle();
         checks++;
         if (lane_vld !== 0 || lane_owner !== 1 || busy !== 1) begin
            errors++;
            $display("FAIL stall[%0d] got vld=%b own=%0d busy=%b want 0 1 1", c, lane_vld, lane_owner, busy);
         end
      end
      lane_en = 1; req_valid = 4'b0010;
      for (int c = 0; c < 4 && busy; c++) begin
         req_data = {$urandom(), $urandom()};
         cycle();
         if (lane_vld) pulses++;
      end
      checks++;
      if (pulses != MB - 1 || busy !== 0) begin
         errors++;
         $display("FAIL stall_resume got %0d beats busy=%b want %0d beats busy=0", pulses, busy, MB - 1);
      end
      req_valid = '0;
   endtask

   task automatic test_reset_midburst();
      do_reset();
      req_valid = 4'b1000; req_last = '0;
      req_data = {$urandom(), $urandom()};
      cycle();
      cycle();
      rst_n = 0;
      cycle();
      checks++;
      if (lane_vld !== 0 || lane_hi_data !== 0 || lane_lo_data !== 0 || busy !== 0 || lane_owner !== 0) begin
         errors++;
         $display("FAIL midreset got vld=%b hi=%h lo=%h busy=%b own=%0d want all zero",
                  lane_vld, lane_hi_data, lane_lo_data, busy, lane_owner);
      end
      rst_n = 1;
      req_valid = 4'b1010;
      cycle();
      checks++;
      if (busy !== 1 || lane_owner !== 1) begin
         errors++;
         $display("FAIL midreset_regrant got busy=%b own=%0d want 1 1", busy, lane_owner);
      end
      req_valid = '0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom());
         req_last  = 4'($urandom() & $urandom());
         lane_en   = ($urandom_range(0, 7) != 0);
         req_data  = {$urandom(), $urandom()};
         rst_n     = ($urandom_range(0, 99) != 0);
         cycle();
      end
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; lane_en = 0; req_valid = '0; req_last = '0; req_data = '0;
      test_reset();
      test_single_beat();
      test_round_robin();
      test_max_burst();
      test_stall();
      test_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
